// File: rtl/run_ctrl_sync.sv
// run_ctrl_sync: run-request synchroniser, debouncer, clock-enable divider and run-control FSM.
//   iClk          system clock, all logic on its rising edge
//   iRst_n        asynchronous active-low reset, released through a 2-flop synchroniser
//   iRunStart     asynchronous run-request level from a pin
//   iCoreDone     run-finished indication from the downstream core (iClk domain)
//   iTimeout      maximum run length in oClkEn ticks, 0 disables the timeout
//   oClkEn        one-cycle enable pulse every CLK_DIV cycles
//   oCoreRunStart clean run level to the downstream core
//   oRunEnd       run completed
//   oTimedOut     last run ended by timeout
//   oState        IDLE=0, ARM=1, RUN=2, DONE=3
module run_ctrl_sync #(
    parameter int SYNC_STAGES = 2,
    parameter int CLK_DIV     = 2,
    parameter int DEBOUNCE    = 4,
    parameter int TIMER_W     = 16
) (
    input  logic               iClk,
    input  logic               iRst_n,
    input  logic               iRunStart,
    input  logic               iCoreDone,
    input  logic [TIMER_W-1:0] iTimeout,
    output logic               oClkEn,
    output logic               oCoreRunStart,
    output logic               oRunEnd,
    output logic               oTimedOut,
    output logic [1:0]         oState
);
    localparam int DW = $clog2(CLK_DIV);
    localparam int BW = $clog2(DEBOUNCE + 1);

    typedef enum logic [1:0] {IDLE, ARM, RUN, DONE} state_t;

    logic [1:0]             rst_q;
    logic                   rst_n;
    logic [DW-1:0]          div_q, div_d;
    logic                   en_q, en_d;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   sync_s;
    logic [BW-1:0]          deb_q, deb_d;
    logic                   req_q, req_d;
    state_t                 state_q, state_d;
    logic [TIMER_W-1:0]     timer_q, timer_d;
    logic                   to_q, to_d;
    logic                   run_q, run_d;
    logic                   end_q, end_d;
    logic                   to_hit, start_run;

    // Assertion propagates asynchronously; release reaches the logic two edges later.
    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) rst_q <= '0;
        else         rst_q <= {rst_q[0], 1'b1};
    end

    assign rst_n  = rst_q[1];
    assign sync_s = sync_q[SYNC_STAGES-1];
    assign div_d  = (div_q == DW'(CLK_DIV - 1)) ? '0 : div_q + DW'(1);
    assign en_d   = div_d == DW'(CLK_DIV - 1);
    // Counter restarts whenever the synchronised input agrees with the filtered request.
    assign deb_d  = (sync_s == req_q || deb_q == BW'(DEBOUNCE - 1)) ? '0 : deb_q + BW'(1);
    assign req_d  = (sync_s != req_q && deb_q == BW'(DEBOUNCE - 1)) ? sync_s : req_q;
    assign to_hit = (iTimeout != '0) && (timer_q == iTimeout);

    always_ff @(posedge iClk or negedge rst_n) begin
        if (!rst_n) begin
            div_q   <= '0;
            en_q    <= 1'b0;
            sync_q  <= '0;
            deb_q   <= '0;
            req_q   <= 1'b0;
            state_q <= IDLE;
            timer_q <= '0;
            to_q    <= 1'b0;
            run_q   <= 1'b0;
            end_q   <= 1'b0;
        end else begin
            div_q   <= div_d;
            en_q    <= en_d;
            sync_q  <= {sync_q[SYNC_STAGES-2:0], iRunStart};
            deb_q   <= deb_d;
            req_q   <= req_d;
            state_q <= state_d;
            timer_q <= timer_d;
            to_q    <= to_d;
            run_q   <= run_d;
            end_q   <= end_d;
        end
    end

    // Abort on a dropped request outranks core completion, which outranks timeout.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: state_d = req_q ? ARM : IDLE;
            ARM:  state_d = !req_q ? IDLE : (en_q ? RUN : ARM);
            RUN:  state_d = !req_q ? IDLE : ((iCoreDone || to_hit) ? DONE : RUN);
            DONE: state_d = req_q ? DONE : IDLE;
        endcase
    end

    always_comb begin
        start_run = (state_q == ARM) && (state_d == RUN);
        timer_d   = start_run ? '0 :
                    (state_q == RUN && en_q && timer_q != '1) ? timer_q + TIMER_W'(1) : timer_q;
        to_d      = start_run ? 1'b0 :
                    (state_q == RUN && req_q && !iCoreDone && to_hit) ? 1'b1 : to_q;
        run_d     = state_q == RUN;
        end_d     = state_q == DONE;
    end

    assign oClkEn        = en_q;
    assign oCoreRunStart = run_q;
    assign oRunEnd       = end_q;
    assign oTimedOut     = to_q;
    assign oState        = state_q;
endmodule

// File: doc/run_ctrl_sync.md
RUN_CTRL_SYNC -- requirements
Module: run_ctrl_sync

Interface
REQ-001 SHALL have parameter SYNC_STAGES, default 2, number of iRunStart synchroniser flops (legal >=2).
REQ-002 SHALL have parameter CLK_DIV, default 2, clock-enable divide ratio (legal >=2).
REQ-003 SHALL have parameter DEBOUNCE, default 4, consecutive stable cycles required to change the filtered run request (legal >=1).
REQ-004 SHALL have parameter TIMER_W, default 16, width of the run timer and iTimeout.
REQ-005 SHALL have port iClk  input  1  system clock; the single clock of the block, all logic on its rising edge.
REQ-006 SHALL have port iRst_n  input  1  reset; asynchronous, active-low.
REQ-007 SHALL have port iRunStart  input  1  asynchronous run-request level from a pin.
REQ-008 SHALL have port iCoreDone  input  1  iClk-synchronous pulse/level from the downstream core: run finished.
REQ-009 SHALL have port iTimeout  input  TIMER_W  maximum run length in oClkEn ticks; 0 disables the timeout.
REQ-010 SHALL have port oClkEn  output  1  one-iClk-wide enable pulse every CLK_DIV cycles.
REQ-011 SHALL have port oCoreRunStart  output  1  clean run level to the downstream core.
REQ-012 SHALL have port oRunEnd  output  1  run completed (level).
REQ-013 SHALL have port oTimedOut  output  1  last run ended by timeout (level).
REQ-014 SHALL have port oState  output  2  FSM state: IDLE=0, ARM=1, RUN=2, DONE=3.

Function
REQ-015 Divider SHALL count 0..CLK_DIV-1, wrap to 0, free-running from reset; oClkEn SHALL be high in exactly the cycle where the count equals CLK_DIV-1.
REQ-016 iRunStart SHALL pass through a SYNC_STAGES-deep flop chain before any other use.
REQ-017 Debouncer SHALL change the filtered request run_req only after the synchroniser output has differed from run_req for DEBOUNCE consecutive cycles; any return to the run_req value SHALL clear the count.
REQ-018 With iRunStart held high, run_req SHALL rise exactly SYNC_STAGES+DEBOUNCE iClk edges after the first edge sampling it high; the same latency applies to the falling direction.
REQ-019 IDLE: oCoreRunStart=0; run_req=1 -> ARM.
REQ-020 ARM: run_req=0 -> IDLE; else on oClkEn=1 -> RUN, clearing the run timer and oTimedOut.
REQ-021 RUN: oCoreRunStart=1; the timer SHALL increment on each oClkEn and saturate at all-ones.
REQ-022 RUN exit priority (highest first): run_req=0 -> IDLE (abort, oRunEnd stays 0); iCoreDone=1 -> DONE; iTimeout!=0 and timer==iTimeout -> DONE with oTimedOut set to 1.
REQ-023 iCoreDone and timeout in the same cycle SHALL give DONE with oTimedOut=0.
REQ-024 DONE: oCoreRunStart=0, oRunEnd=1; run_req=0 -> IDLE, clearing oRunEnd; oTimedOut SHALL hold until the next ARM->RUN.
REQ-025 iCoreDone outside RUN SHALL be ignored.
REQ-026 All outputs SHALL be registered; oCoreRunStart and oRunEnd SHALL change in the cycle after the state transition.

Reset
REQ-027 iRst_n low SHALL asynchronously force: divider=0, synchroniser flops=0, debounce count=0, run_req=0, timer=0, state=IDLE, and oClkEn=0, oCoreRunStart=0, oRunEnd=0, oTimedOut=0, oState=0.
REQ-028 Reset SHALL be released synchronously via the team's 2-flop release synchroniser; reset asserted mid-RUN SHALL drop oCoreRunStart in the same cycle, with no oRunEnd.

Verification
REQ-029 Default parameters, iRst_n released, iRunStart=0 -> oClkEn pulses every 2nd cycle; all other outputs stay 0.
REQ-030 iRunStart rises, held high -> run_req after 6 edges; ARM->RUN on the next oClkEn; oCoreRunStart=1; iCoreDone pulse -> oRunEnd=1, oTimedOut=0, oState=3.
REQ-031 iTimeout=5, no iCoreDone -> DONE after 5 oClkEn ticks in RUN; oTimedOut=1.
REQ-032 iTimeout=5 with iCoreDone on the timeout cycle -> DONE, oTimedOut=0.
REQ-033 iRunStart glitch of 3 cycles high -> run_req never asserts; state stays IDLE.
REQ-034 iRunStart dropped mid-RUN (held low >=6 cycles) -> IDLE, oRunEnd=0; iRst_n low mid-RUN -> all outputs 0 asynchronously.
